// File: rtl/alu_pkg.sv
// Opcodes, status-flag indices and the multiplier sequencer state encoding,
// shared by the 16-bit ALU and the blocks that drive it.
package alu_pkg;

  localparam logic [4:0] ALU_NOP = 5'b00000;
  localparam logic [4:0] ALU_ADD = 5'b00100;
  localparam logic [4:0] ALU_RCR = 5'b10111;

  // Bit positions inside alu_status {CF,ZF,NF,VF,PF,AF}
  localparam int CF = 5;
  localparam int ZF = 4;
  localparam int NF = 3;
  localparam int VF = 2;
  localparam int PF = 1;
  localparam int AF = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADD    = 3'd1,
    ST_RCR_HI = 3'd2,
    ST_RCR_LO = 3'd3,
    ST_DONE   = 3'd4
  } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// 16x16 unsigned shift-add multiplier that borrows the shared ALU: each of the
// 16 iterations is ADD, RCR of P_hi, RCR of P_lo, so latency never depends on data.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int CF_BIT = CF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_product,
  output logic        out_zero,
  output logic        busy,
  output logic [4:0]  alu_f,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_cin,
  input  logic [15:0] alu_result,
  input  logic [5:0]  alu_status
);

  mul_state_e  state;
  logic [15:0] m, p_hi, p_lo;
  logic        c;
  logic [3:0]  cnt;
  logic        zero_q;

  // Only the carry flag feeds the datapath.
  logic unused_status;
  assign unused_status = ^{alu_status[5:0]};

  assign in_ready    = (state == ST_IDLE);
  assign out_valid   = (state == ST_DONE);
  assign busy        = (state != ST_IDLE);
  assign out_product = {p_hi, p_lo};
  assign out_zero    = zero_q;

  always_comb begin
    alu_f   = ALU_NOP;
    alu_a   = 16'h0000;
    alu_b   = 16'h0000;
    alu_cin = 1'b0;
    case (state)
      ST_ADD: begin
        alu_f = ALU_ADD;
        alu_a = p_hi;
        alu_b = p_lo[0] ? m : 16'h0000;
      end
      ST_RCR_HI: begin
        alu_f   = ALU_RCR;
        alu_a   = p_hi;
        alu_cin = c;
      end
      ST_RCR_LO: begin
        alu_f   = ALU_RCR;
        alu_a   = p_lo;
        alu_cin = c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      m      <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      zero_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          m     <= in_a;
          p_lo  <= in_b;
          p_hi  <= '0;
          c     <= 1'b0;
          cnt   <= '0;
          state <= ST_ADD;
        end
        ST_ADD: begin
          p_hi  <= alu_result;
          c     <= alu_status[CF_BIT];
          state <= ST_RCR_HI;
        end
        ST_RCR_HI: begin
          p_hi  <= alu_result;
          c     <= alu_status[CF_BIT];
          state <= ST_RCR_LO;
        end
        ST_RCR_LO: begin
          p_lo <= alu_result;
          c    <= 1'b0;
          if (cnt == 4'd15) begin
            // Final product is {p_hi, alu_result}; flag it while it lands.
            zero_q <= ({p_hi, alu_result} == 32'h0);
            state  <= ST_DONE;
          end else begin
            cnt   <= cnt + 4'd1;
            state <= ST_ADD;
          end
        end
        ST_DONE: if (out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: a behavioural ALU closes the loop, products are
// checked against plain a*b along with latency and handshake behaviour.
module tb_alu_mul_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0, in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_product;
  logic        out_zero;
  logic        busy;
  logic [4:0]  alu_f;
  logic [15:0] alu_a, alu_b;
  logic        alu_cin;
  logic [15:0] alu_result;
  logic [5:0]  alu_status;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_mul_seq #(.CF_BIT(CF)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_zero(out_zero), .busy(busy),
    .alu_f(alu_f), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_status(alu_status)
  );

  // Behavioural ALU: ADD with carry out, RCR rotates right through carry.
  logic [16:0] alu_sum;
  logic        alu_cf;
  always_comb begin
    alu_sum    = 17'h0;
    alu_result = 16'h0;
    alu_cf     = 1'b0;
    case (alu_f)
      ALU_ADD: begin
        alu_sum    = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0, alu_cin};
        alu_result = alu_sum[15:0];
        alu_cf     = alu_sum[16];
      end
      ALU_RCR: begin
        alu_result = {alu_cin, alu_a[15:1]};
        alu_cf     = alu_a[0];
      end
      default: ;
    endcase
    alu_status = {alu_cf, (alu_result == 16'h0), alu_result[15], 1'b0, ~^alu_result, 1'b0};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'h0, in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'h0, out_valid}, 32'd0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'd0);
    chk({tag, "_alu"}, {alu_f, alu_a, 10'h0, alu_cin}, 32'h0);
  endtask

  // Accept a, b; optionally inject a stray in_valid at cycle glitch and
  // hold out_ready low for stall cycles once the product is presented.
  task automatic do_mul(input logic [15:0] a, input logic [15:0] b,
                        input int glitch, input int stall);
    logic [31:0] exp;
    int n;
    int w;
    exp = 32'(a) * 32'(b);
    w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
    chk("busy_after_accept", {31'h0, busy}, 32'd1);
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1; n++;
      if (in_valid) in_valid = 1'b0;
      if (out_valid) break;
      if (n == glitch) begin
        in_a = ~a; in_b = b + 16'd3; in_valid = 1'b1;
      end
    end
    in_valid = 1'b0;
    chk("latency", 32'(n), 32'd48);
    chk("product", out_product, exp);
    chk("zero", {31'h0, out_zero}, {31'h0, exp == 32'h0});
    chk("in_ready_done", {31'h0, in_ready}, 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'h0, out_valid}, 32'd1);
      chk("stall_product", out_product, exp);
      chk("stall_in_ready", {31'h0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("back_to_idle", {31'h0, in_ready}, 32'd1);
    chk("valid_dropped", {31'h0, out_valid}, 32'd0);
  endtask

  initial begin
    #1;
    chk_idle_outputs("reset");
    chk("reset_product", out_product, 32'h0);
    chk("reset_zero", {31'h0, out_zero}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_mul(16'd3, 16'd5, 0, 0);
    do_mul(16'hFFFF, 16'hFFFF, 0, 0);
    do_mul(16'h1234, 16'h5678, 0, 0);
    do_mul(16'h0000, 16'hABCD, 0, 0);
    do_mul(16'hABCD, 16'h0000, 0, 0);
    do_mul(16'h8001, 16'h0001, 0, 10);
    do_mul(16'h00C3, 16'h0E11, 0, 0);
    do_mul(16'h4321, 16'h1111, 20, 0);

    // Abort mid-run with an asynchronous reset.
    in_a = 16'h00FF; in_b = 16'h0101; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (25) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_idle_outputs("abort");
    chk("abort_product", out_product, 32'h0);
    chk("abort_zero", {31'h0, out_zero}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (out_valid) chk("abort_no_valid", 32'd1, 32'd0);
    end
    do_mul(16'd7, 16'd9, 0, 0);

    for (int i = 0; i < 10; i++)
      do_mul(16'($urandom), 16'($urandom), 0, int'($urandom_range(0, 3)));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
